// File: rtl/iseq_pkg.sv
// Shared opcode constants, opcode field position and FSM state type for iseq_receiver.
// The PAD state only exists when ISEQ_PAD_EN is defined.
package iseq_pkg;

   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 28;

   localparam logic [3:0] OPC_END_ISEQ = 4'hE;
   localparam logic [3:0] OPC_NOP      = 4'h0;

   typedef enum logic [2:0] {
      StRecv   = 3'd0,
`ifdef ISEQ_PAD_EN
      StPad    = 3'd1,
`endif
      StStart  = 3'd2,
      StWaitHi = 3'd3,
      StWaitLo = 3'd4
   } iseq_state_e;

endpackage

// File: rtl/instr_fifo.sv
// First-word-fall-through FIFO: rdata shows the head whenever empty is low, rd pops it.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module instr_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd,
   output logic             empty,
   output logic             full,
   output logic [WIDTH-1:0] rdata
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_wr;
   logic             do_rd;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_rd = rd && !empty;
   // A pop in the same cycle frees the slot being written.
   assign do_wr = wr && (!full || do_rd);
   assign rdata = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_wr) wptr <= wptr + PTR_ONE;
         if (do_rd) rptr <= rptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/iseq_receiver.sv
// Buffers host instructions into two alternating lane FIFOs and kicks the dispatcher on END_ISEQ.
// Define ISEQ_PAD_EN to pad odd-length sequences with a NOP in lane 1.
module iseq_receiver
   import iseq_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 64,
   parameter int unsigned INSTR_WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           app_en,
   input  logic [INSTR_WIDTH-1:0]         app_instr,
   output logic                           app_ack,
   input  logic                           dispatcher_busy,
   output logic                           process_iseq,
   input  logic                           instr0_fifo_rd,
   input  logic                           instr1_fifo_rd,
   output logic                           instr0_fifo_empty,
   output logic                           instr1_fifo_empty,
   output logic [INSTR_WIDTH-1:0]         instr0_fifo_data,
   output logic [INSTR_WIDTH-1:0]         instr1_fifo_data,
   output logic [$clog2(2*FIFO_DEPTH):0]  iseq_len
);

   localparam int unsigned LEN_W = $clog2(2*FIFO_DEPTH) + 1;
   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   iseq_state_e            state;
   logic                   lane_ptr;
   logic                   is_end;
   logic                   tgt_full;
   logic                   accept_word;
   logic                   full0;
   logic                   full1;
   logic                   wr0;
   logic                   wr1;
   logic [INSTR_WIDTH-1:0] wdata1;

   assign is_end      = (app_instr[OPC_MSB:OPC_LSB] == OPC_END_ISEQ);
   assign tgt_full    = lane_ptr ? full1 : full0;
   assign app_ack     = app_en && !rst && (state == StRecv) && (is_end || !tgt_full);
   assign accept_word = app_ack && !is_end;
   assign wr0         = accept_word && !lane_ptr;

`ifdef ISEQ_PAD_EN
   assign wr1 = (accept_word && lane_ptr) || (state == StPad);

   always_comb begin
      wdata1 = app_instr;
      if (state == StPad) begin
         wdata1                  = '0;
         wdata1[OPC_MSB:OPC_LSB] = OPC_NOP;
      end
   end
`else
   assign wr1    = accept_word && lane_ptr;
   assign wdata1 = app_instr;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= StRecv;
         lane_ptr     <= 1'b0;
         iseq_len     <= '0;
         process_iseq <= 1'b0;
      end else begin
         process_iseq <= 1'b0;
         unique case (state)
            StRecv: begin
               if (accept_word) begin
                  lane_ptr <= ~lane_ptr;
                  if (iseq_len != '1) iseq_len <= iseq_len + LEN_ONE;
               end else if (app_ack && (iseq_len != '0)) begin
`ifdef ISEQ_PAD_EN
                  if (lane_ptr) begin
                     state <= StPad;
                  end else begin
                     state        <= StStart;
                     process_iseq <= 1'b1;
                  end
`else
                  state        <= StStart;
                  process_iseq <= 1'b1;
`endif
               end
            end
`ifdef ISEQ_PAD_EN
            StPad: begin
               lane_ptr     <= ~lane_ptr;
               state        <= StStart;
               process_iseq <= 1'b1;
            end
`endif
            StStart:  state <= StWaitHi;
            StWaitHi: if (dispatcher_busy) state <= StWaitLo;
            StWaitLo: begin
               if (!dispatcher_busy) begin
                  state    <= StRecv;
                  lane_ptr <= 1'b0;
                  iseq_len <= '0;
               end
            end
            default:  state <= StRecv;
         endcase
      end
   end

   instr_fifo #(
      .WIDTH (INSTR_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_lane0 (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr0),
      .wdata (app_instr),
      .rd    (instr0_fifo_rd),
      .empty (instr0_fifo_empty),
      .full  (full0),
      .rdata (instr0_fifo_data)
   );

   instr_fifo #(
      .WIDTH (INSTR_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_lane1 (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr1),
      .wdata (wdata1),
      .rd    (instr1_fifo_rd),
      .empty (instr1_fifo_empty),
      .full  (full1),
      .rdata (instr1_fifo_data)
   );

endmodule

// File: tb/tb_iseq_receiver.sv
// Self-checking bench for iseq_receiver: table of sequence shapes, random sequences against a
// lane-queue model, and hand-written full-FIFO, busy-handshake and reset corner cases.
module tb_iseq_receiver;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned W     = 32;
   localparam int unsigned LW    = $clog2(2*DEPTH) + 1;
`ifdef ISEQ_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif
   localparam logic [W-1:0] END_WORD = 32'hE000_0000;

   logic          clk = 1'b0;
   logic          rst;
   logic          app_en;
   logic [W-1:0]  app_instr;
   logic          app_ack;
   logic          dispatcher_busy;
   logic          process_iseq;
   logic          instr0_fifo_rd;
   logic          instr1_fifo_rd;
   logic          instr0_fifo_empty;
   logic          instr1_fifo_empty;
   logic [W-1:0]  instr0_fifo_data;
   logic [W-1:0]  instr1_fifo_data;
   logic [LW-1:0] iseq_len;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   iseq_receiver #(
      .FIFO_DEPTH  (DEPTH),
      .INSTR_WIDTH (W)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .app_en            (app_en),
      .app_instr         (app_instr),
      .app_ack           (app_ack),
      .dispatcher_busy   (dispatcher_busy),
      .process_iseq      (process_iseq),
      .instr0_fifo_rd    (instr0_fifo_rd),
      .instr1_fifo_rd    (instr1_fifo_rd),
      .instr0_fifo_empty (instr0_fifo_empty),
      .instr1_fifo_empty (instr1_fifo_empty),
      .instr0_fifo_data  (instr0_fifo_data),
      .instr1_fifo_data  (instr1_fifo_data),
      .iseq_len          (iseq_len)
   );

   typedef struct {
      int    n;
      int    len;
      int    l0;
      int    l1;
      int    dly;
      int    nb;
      string name;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] w;
      w = $urandom;
      if (w[31:28] == 4'hE) w[31:28] = 4'h5;
      return w;
   endfunction

   task automatic do_reset(input bit chk);
      rst = 1'b1;
      app_en = 1'b1;
      app_instr = 32'h1234_5678;
      @(negedge clk);
      if (chk) check("ack_during_rst", app_ack, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      app_en = 1'b0;
      @(negedge clk);
      if (chk) begin
         check("rst_empty0", instr0_fifo_empty, 1);
         check("rst_empty1", instr1_fifo_empty, 1);
         check("rst_len", iseq_len, 0);
         check("rst_pulse", process_iseq, 0);
      end
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [W-1:0] w, output int waited);
      waited = 0;
      app_en = 1'b1;
      app_instr = w;
      @(negedge clk);
      while (!app_ack && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (!app_ack) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got no ack, expected ack for 0x%0h", w);
      end
      @(posedge clk); #1;
      app_en = 1'b0;
      app_instr = '0;
   endtask

   task automatic wait_pulse(output int first, output int hi);
      first = 0;
      hi = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (process_iseq) begin
            hi++;
            if (first == 0) first = k;
         end
      end
      @(posedge clk); #1;
   endtask

   // Dispatcher held busy for nb+1 cycles; an END is offered throughout so app_ack is observable.
   task automatic busy_cycle(input int nb, input string tag);
      dispatcher_busy = 1'b1;
      app_en = 1'b1;
      app_instr = END_WORD;
      @(negedge clk);
      check({tag, "_ack_wait_hi"}, app_ack, 0);
      @(posedge clk); #1;
      for (int i = 0; i < nb; i++) begin
         @(negedge clk);
         check({tag, "_ack_busy"}, app_ack, 0);
         @(posedge clk); #1;
      end
      dispatcher_busy = 1'b0;
      @(negedge clk);
      check({tag, "_ack_busy_fall"}, app_ack, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, "_ack_back"}, app_ack, 1);
      check({tag, "_len_clear"}, iseq_len, 0);
      @(posedge clk); #1;
      app_en = 1'b0;
   endtask

   task automatic drain_lane(input bit lane, input logic [W-1:0] q[$], input int exp_cnt,
                             input string tag);
      int cnt;
      logic [W-1:0] act;
      cnt = 0;
      while (cnt < 2*DEPTH + 4) begin
         @(negedge clk);
         if (lane ? instr1_fifo_empty : instr0_fifo_empty) break;
         act = lane ? instr1_fifo_data : instr0_fifo_data;
         if (cnt < q.size()) check({tag, lane ? "_l1_data" : "_l0_data"}, act, q[cnt]);
         if (lane) instr1_fifo_rd = 1'b1;
         else instr0_fifo_rd = 1'b1;
         @(posedge clk); #1;
         instr0_fifo_rd = 1'b0;
         instr1_fifo_rd = 1'b0;
         cnt++;
      end
      @(posedge clk); #1;
      check({tag, lane ? "_l1_count" : "_l0_count"}, cnt, exp_cnt);
   endtask

   // Lane model: word i goes to lane i%2; with padding an odd sequence gets a zero NOP in lane 1.
   task automatic run_seq(input int n, input int exp_len, input int exp_l0, input int exp_l1,
                          input int exp_delay, input int nb, input string tag);
      logic [W-1:0] q0[$];
      logic [W-1:0] q1[$];
      logic [W-1:0] w;
      int waited, first, hi;
      for (int i = 0; i < n; i++) begin
         w = rand_word();
         if (i % 2 == 0) q0.push_back(w);
         else q1.push_back(w);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         send(w, waited);
      end
      if (PAD && (n % 2 == 1)) q1.push_back('0);
      @(negedge clk);
      check({tag, "_len"}, iseq_len, exp_len);
      @(posedge clk); #1;
      send(END_WORD, waited);
      check({tag, "_end_ack_wait"}, waited, 0);
      wait_pulse(first, hi);
      check({tag, "_pulse_at"}, first, exp_delay);
      check({tag, "_pulse_cnt"}, hi, (exp_delay != 0) ? 1 : 0);
      if (exp_delay != 0) busy_cycle(nb, tag);
      drain_lane(1'b0, q0, exp_l0, tag);
      drain_lane(1'b1, q1, exp_l1, tag);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] wq[$];
      logic [W-1:0] q0[$];
      logic [W-1:0] w;
      int waited, fill_wait, n, first, hi;

      tbl[0] = '{0, 0, 0, 0, 0, 1, "end_only"};
      tbl[1] = '{4, 4, 2, 2, 1, 2, "four"};
      tbl[2] = '{3, 3, 2, PAD ? 2 : 1, PAD ? 2 : 1, 1, "three"};
      tbl[3] = '{1, 1, 1, PAD ? 1 : 0, PAD ? 2 : 1, 3, "one"};
      tbl[4] = '{2, 2, 1, 1, 1, 9, "two_busy10"};
      tbl[5] = '{5, 5, 3, PAD ? 3 : 2, PAD ? 2 : 1, 2, "five"};

      rst = 1'b1;
      app_en = 1'b0;
      app_instr = '0;
      dispatcher_busy = 1'b0;
      instr0_fifo_rd = 1'b0;
      instr1_fifo_rd = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset(1'b1);

      foreach (tbl[i]) begin
         run_seq(tbl[i].n, tbl[i].len, tbl[i].l0, tbl[i].l1, tbl[i].dly, tbl[i].nb, tbl[i].name);
      end

      for (int r = 0; r < 20; r++) begin
         n = $urandom_range(0, 10);
         run_seq(n, n, (n + 1) / 2, n / 2 + ((PAD && (n % 2 == 1)) ? 1 : 0),
                 (n == 0) ? 0 : ((PAD && (n % 2 == 1)) ? 2 : 1), $urandom_range(1, 4), "rnd");
      end

      // Fill both lanes, then the next word must stall until lane 0 is popped.
      do_reset(1'b0);
      fill_wait = 0;
      for (int i = 0; i < 2*DEPTH; i++) begin
         w = rand_word();
         wq.push_back(w);
         send(w, waited);
         fill_wait += waited;
      end
      check("fill_no_stall", fill_wait, 0);
      w = rand_word();
      app_en = 1'b1;
      app_instr = w;
      repeat (3) begin
         @(negedge clk);
         check("full_stall", app_ack, 0);
         @(posedge clk); #1;
      end
      instr0_fifo_rd = 1'b1;
      @(negedge clk);
      check("full_stall_pop", app_ack, 0);
      check("full_head", instr0_fifo_data, wq[0]);
      @(posedge clk); #1;
      instr0_fifo_rd = 1'b0;
      @(negedge clk);
      check("accept_after_pop", app_ack, 1);
      @(posedge clk); #1;
      app_en = 1'b0;
      @(negedge clk);
      check("len_full_plus1", iseq_len, 2*DEPTH + 1);
      @(posedge clk); #1;
      for (int i = 2; i < 2*DEPTH; i += 2) q0.push_back(wq[i]);
      q0.push_back(w);
      drain_lane(1'b0, q0, DEPTH, "full");
      do_reset(1'b1);

      // Reset while the dispatcher is busy must return to a receiving, empty state.
      for (int i = 0; i < 3; i++) send(rand_word(), waited);
      send(END_WORD, waited);
      wait_pulse(first, hi);
      check("rstbusy_pulse_cnt", hi, 1);
      dispatcher_busy = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      app_en = 1'b1;
      app_instr = END_WORD;
      @(negedge clk);
      check("rstbusy_empty0", instr0_fifo_empty, 1);
      check("rstbusy_empty1", instr1_fifo_empty, 1);
      check("rstbusy_len", iseq_len, 0);
      check("rstbusy_ack", app_ack, 1);
      @(posedge clk); #1;
      app_en = 1'b0;
      dispatcher_busy = 1'b0;
      @(negedge clk);
      check("rstbusy_no_pulse", process_iseq, 0);
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
